// File: rtl/ht25_encoder.sv
// Table-25 Huffman encoder for MP3 big-value pairs: serialises codeword, x linbits/sign,
// y linbits/sign one bit per cycle, MSB first; next pair may be accepted on the last bit.
module ht25_encoder #(
  parameter int LINBITS = 5,
  parameter int MAX_CW  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        axiiv,
  input  logic [15:0] x_val,
  input  logic [15:0] y_val,
  output logic        axiir,
  output logic        axiov,
  output logic        axiod,
  output logic        axiol,
  output logic        ovf
);
  localparam int SRW = MAX_CW + 2 * LINBITS + 2;
  localparam logic [5:0] MAXMAG = 6'(15 + (1 << LINBITS) - 1);

  // Table-24 codebook, indexed by {x_index, y_index}.
  localparam int CW_TAB [256] = '{
    15, 13, 46, 80, 146, 262, 248, 434, 426, 669, 653, 649, 621, 517, 1032, 88,
    14, 12, 21, 38, 71, 130, 122, 216, 209, 198, 327, 345, 319, 297, 279, 42,
    47, 22, 41, 74, 68, 128, 120, 221, 207, 194, 182, 340, 315, 295, 541, 18,
    81, 39, 75, 70, 134, 125, 116, 220, 204, 190, 178, 325, 311, 293, 271, 16,
    147, 72, 69, 135, 127, 118, 112, 210, 200, 188, 352, 323, 306, 285, 540, 14,
    263, 66, 129, 126, 119, 114, 214, 202, 192, 180, 341, 317, 301, 281, 262, 12,
    249, 123, 121, 117, 113, 215, 206, 195, 185, 347, 330, 308, 291, 272, 520, 10,
    435, 115, 111, 109, 211, 203, 196, 187, 353, 332, 313, 298, 283, 531, 381, 17,
    427, 212, 208, 205, 201, 193, 186, 177, 169, 320, 303, 286, 268, 514, 377, 16,
    335, 199, 197, 191, 189, 181, 174, 333, 321, 305, 289, 275, 521, 379, 371, 11,
    668, 184, 183, 179, 175, 344, 331, 314, 304, 290, 277, 530, 383, 373, 366, 10,
    652, 346, 171, 168, 164, 318, 309, 299, 287, 276, 263, 513, 375, 368, 362, 6,
    648, 322, 316, 312, 307, 302, 292, 284, 269, 261, 512, 376, 370, 364, 359, 4,
    620, 300, 296, 294, 288, 282, 273, 266, 515, 380, 374, 369, 365, 361, 357, 2,
    1033, 280, 278, 274, 267, 264, 259, 382, 378, 372, 367, 363, 360, 358, 356, 0,
    43, 20, 19, 17, 15, 13, 11, 9, 7, 6, 4, 7, 5, 3, 1, 3
  };

  localparam int CL_TAB [256] = '{
    4, 4, 6, 7, 8, 9, 9, 10, 10, 11, 11, 11, 11, 11, 12, 9,
    4, 4, 5, 6, 7, 8, 8, 9, 9, 9, 10, 10, 10, 10, 10, 8,
    6, 5, 6, 7, 7, 8, 8, 9, 9, 9, 9, 10, 10, 10, 11, 7,
    7, 6, 7, 7, 8, 8, 8, 9, 9, 9, 9, 10, 10, 10, 10, 7,
    8, 7, 7, 8, 8, 8, 8, 9, 9, 9, 10, 10, 10, 10, 11, 7,
    9, 7, 8, 8, 8, 8, 9, 9, 9, 9, 10, 10, 10, 10, 10, 7,
    9, 8, 8, 8, 8, 9, 9, 9, 9, 10, 10, 10, 10, 10, 11, 7,
    10, 8, 8, 8, 9, 9, 9, 9, 10, 10, 10, 10, 10, 11, 11, 8,
    10, 9, 9, 9, 9, 9, 9, 9, 9, 10, 10, 10, 10, 11, 11, 8,
    10, 9, 9, 9, 9, 9, 9, 10, 10, 10, 10, 10, 11, 11, 11, 8,
    11, 9, 9, 9, 9, 10, 10, 10, 10, 10, 10, 11, 11, 11, 11, 8,
    11, 10, 9, 9, 9, 10, 10, 10, 10, 10, 10, 11, 11, 11, 11, 8,
    11, 10, 10, 10, 10, 10, 10, 10, 10, 10, 11, 11, 11, 11, 11, 8,
    11, 10, 10, 10, 10, 10, 10, 10, 11, 11, 11, 11, 11, 11, 11, 8,
    12, 10, 10, 10, 10, 10, 10, 11, 11, 11, 11, 11, 11, 11, 11, 8,
    8, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 8, 8, 8, 8, 4
  };

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [SRW-1:0]  sr_q, sr_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic [6:0]      xm, ym;
  logic [3:0]      xi, yi;
  logic [MAX_CW-1:0] cw;
  logic [4:0]      len;
  logic [SRW-1:0]  acc, sr_load;

  // Returns {saturated, |v| clipped to MAXMAG}; -32768 negates to 0x8000 and saturates.
  function automatic logic [6:0] sat_mag(input logic [15:0] v);
    logic [15:0] a;
    a = v[15] ? (~v + 16'd1) : v;
    if (a > {10'd0, MAXMAG}) return {1'b1, MAXMAG};
    return {1'b0, a[5:0]};
  endfunction

  always_comb begin
    xm = sat_mag(x_val);
    ym = sat_mag(y_val);
    xi = (xm[5:0] >= 6'd15) ? 4'd15 : xm[3:0];
    yi = (ym[5:0] >= 6'd15) ? 4'd15 : ym[3:0];
    cw = MAX_CW'(CW_TAB[{xi, yi}]);
    len = 5'(CL_TAB[{xi, yi}]);
    acc = SRW'(cw);
    if (xi == 4'd15) begin
      acc = {acc[SRW-LINBITS-1:0], LINBITS'(xm[5:0] - 6'd15)};
      len = len + 5'(LINBITS);
    end
    if (xm[5:0] != 6'd0) begin
      acc = {acc[SRW-2:0], x_val[15]};
      len = len + 5'd1;
    end
    if (yi == 4'd15) begin
      acc = {acc[SRW-LINBITS-1:0], LINBITS'(ym[5:0] - 6'd15)};
      len = len + 5'(LINBITS);
    end
    if (ym[5:0] != 6'd0) begin
      acc = {acc[SRW-2:0], y_val[15]};
      len = len + 5'd1;
    end
    sr_load = acc << (5'(SRW) - len);
  end

  assign axiir  = (state_q == IDLE) || ((state_q == SEND) && (count_q == 5'd1));
  assign accept = axiiv && axiir;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sr_d    = sr_q;
    ovf_d   = 1'b0;
    case (state_q)
      SEND: begin
        sr_d    = {sr_q[SRW-2:0], 1'b0};
        count_d = count_q - 5'd1;
        if (count_q == 5'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A load on the last bit overrides the shift, giving zero-gap back-to-back pairs.
    if (accept) begin
      state_d = SEND;
      sr_d    = sr_load;
      count_d = len;
      ovf_d   = xm[6] | ym[6];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 5'd0;
      sr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sr_q    <= sr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign axiov = (state_q == SEND);
  assign axiod = axiov & sr_q[SRW-1];
  assign axiol = axiov & (count_q == 5'd1);
  assign ovf   = ovf_q;

endmodule
